serial_cfg_register: RTL and testbench

SERIAL_CFG_REGISTER -- requirements
Module: serial_cfg_register

---
 rtl/serial_cfg_register.sv | 143 ++++++++++++++
 tb/tb_serial_cfg_register.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_cfg_register.sv
// Serial configuration register.
// A frame of WIDTH bits is shifted in on an external sclk, LSB first, into a
// shadow register and copied to the active register by an external lclk pulse
// only when exactly WIDTH bits have been shifted since the previous load
// attempt. Both external clocks are oversampled by clk through synchronizers,
// and sdi goes through a synchronizer of the same depth so that it stays
// aligned with sclk.
module serial_cfg_register #(
    parameter int              WIDTH         = 24,
    parameter int              SYNC_STAGES   = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE   = '0,
    parameter logic [WIDTH-1:0] DISABLE_VALUE = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sclk_in,
    input  logic                         lclk_in,
    input  logic                         sdi,
    input  logic                         en_n,
    output logic [WIDTH-1:0]             cfg_out,
    output logic                         sdo,
    output logic                         load_strobe,
    output logic                         frame_err,
    output logic [$clog2(WIDTH+2)-1:0]   bit_count
);

    localparam int CW   = $clog2(WIDTH + 2);
    localparam int LAST = SYNC_STAGES - 1;

    // Index 0 is sclk, index 1 is lclk.
    logic [1:0]             line_in;
    logic [1:0]             line_rise;
    logic [1:0]             line_evt_reg;
    logic [SYNC_STAGES-1:0] sync_valid_reg;
    logic [SYNC_STAGES-1:0] sdi_sync_reg;
    logic                   sdi_bit_reg;

    logic [WIDTH-1:0]       shadow_reg;
    logic [WIDTH-1:0]       active_reg;
    logic [CW-1:0]          bit_count_reg;
    logic                   frame_err_reg;
    logic                   load_accept_reg;
    logic                   load_strobe_reg;

    logic                   sclk_evt;
    logic                   lclk_evt;
    logic                   frame_full;

    assign line_in = {lclk_in, sclk_in};

    // Marks which synchronizer stages hold real samples taken after reset,
    // so that the reset zeros are never mistaken for an observed low level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_valid_reg <= '0;
        end else begin
            sync_valid_reg <= {sync_valid_reg[SYNC_STAGES-2:0], 1'b1};
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_line
            logic [SYNC_STAGES-1:0] sync_reg;
            logic                   prev_reg;
            logic                   armed_reg;

            // Synchronize the external clock and keep a delayed copy for
            // edge detection; a rise only counts once a genuine low has been
            // seen after reset, so a line already high at release is ignored.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sync_reg  <= '0;
                    prev_reg  <= 1'b0;
                    armed_reg <= 1'b0;
                end else begin
                    sync_reg  <= {sync_reg[SYNC_STAGES-2:0], line_in[gi]};
                    prev_reg  <= sync_reg[LAST];
                    armed_reg <= armed_reg | (sync_valid_reg[LAST] & ~sync_reg[LAST]);
                end
            end

            assign line_rise[gi] = sync_reg[LAST] & ~prev_reg & armed_reg;
        end
    endgenerate

    // Data synchronizer of the same depth, and registered single-cycle
    // events with the sdi sample captured alongside the sclk rise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sdi_sync_reg <= '0;
            sdi_bit_reg  <= 1'b0;
            line_evt_reg <= '0;
        end else begin
            sdi_sync_reg <= {sdi_sync_reg[SYNC_STAGES-2:0], sdi};
            sdi_bit_reg  <= sdi_sync_reg[LAST];
            line_evt_reg <= line_rise;
        end
    end

    assign sclk_evt   = line_evt_reg[0];
    assign lclk_evt   = line_evt_reg[1];
    assign frame_full = (bit_count_reg == CW'(WIDTH));

    // Shift, count and load. A load in the same cycle as a shift judges the
    // pre-shift shadow and count, then the shift lands as bit 1 of a new frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_reg      <= '0;
            active_reg      <= RESET_VALUE;
            bit_count_reg   <= '0;
            frame_err_reg   <= 1'b0;
            load_accept_reg <= 1'b0;
            load_strobe_reg <= 1'b0;
        end else begin
            load_accept_reg <= lclk_evt & frame_full;
            load_strobe_reg <= load_accept_reg;

            if (sclk_evt) begin
                shadow_reg <= {sdi_bit_reg, shadow_reg[WIDTH-1:1]};
            end

            if (lclk_evt) begin
                if (frame_full) begin
                    active_reg    <= shadow_reg;
                    frame_err_reg <= 1'b0;
                end else begin
                    frame_err_reg <= 1'b1;
                end
                bit_count_reg <= sclk_evt ? CW'(1) : '0;
            end else if (sclk_evt && (bit_count_reg != CW'(WIDTH + 1))) begin
                bit_count_reg <= bit_count_reg + CW'(1);
            end
        end
    end

    assign cfg_out     = en_n ? DISABLE_VALUE : active_reg;
    assign sdo         = shadow_reg[0];
    assign load_strobe = load_strobe_reg;
    assign frame_err   = frame_err_reg;
    assign bit_count   = bit_count_reg;

endmodule

// File: tb/tb_serial_cfg_register.sv
// Self-checking bench for serial_cfg_register with randomized frames checked
// against a frame-level reference model (bit history queue + shift counter).
module tb_serial_cfg_register;

    localparam int              W  = 24;
    localparam int              S  = 2;
    localparam int              CW = $clog2(W + 2);
    localparam logic [W-1:0]    RV = 24'hC0FFEE;
    localparam logic [W-1:0]    DV = 24'h0F0F0F;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sclk_in = 1'b0;
    logic          lclk_in = 1'b0;
    logic          sdi = 1'b0;
    logic          en_n = 1'b0;
    logic [W-1:0]  cfg_out;
    logic          sdo;
    logic          load_strobe;
    logic          frame_err;
    logic [CW-1:0] bit_count;

    int n_tests = 0;
    int n_fail  = 0;

    serial_cfg_register #(
        .WIDTH(W), .SYNC_STAGES(S), .RESET_VALUE(RV), .DISABLE_VALUE(DV)
    ) dut (
        .clk(clk), .rst(rst), .sclk_in(sclk_in), .lclk_in(lclk_in), .sdi(sdi),
        .en_n(en_n), .cfg_out(cfg_out), .sdo(sdo), .load_strobe(load_strobe),
        .frame_err(frame_err), .bit_count(bit_count)
    );

    always #5 clk = ~clk;

    // Number of clk cycles load_strobe has been seen high.
    int strobe_hi = 0;
    always @(posedge clk) if (load_strobe) strobe_hi <= strobe_hi + 1;

    // Reference model: bits shifted since reset (newest last), shifts since
    // the last load attempt, active word and error flag.
    bit           hist[$];
    int           n_shift  = 0;
    logic [W-1:0] m_active = RV;
    bit           m_err    = 0;
    int           exp_strobes = 0;
    int           got_strobes = 0;

    function automatic logic [W-1:0] exp_shadow();
        logic [W-1:0] r = '0;
        for (int i = 0; i < W; i++) begin
            int idx = hist.size() - W + i;
            if (idx >= 0) r[i] = hist[idx];
        end
        return r;
    endfunction

    function automatic int exp_count();
        return (n_shift > W + 1) ? W + 1 : n_shift;
    endfunction

    function automatic bit exp_sdo();
        logic [W-1:0] s = exp_shadow();
        return s[0];
    endfunction

    task automatic model_shift(input bit b);
        hist.push_back(b);
        if (hist.size() > W) void'(hist.pop_front());
        n_shift++;
    endtask

    task automatic model_load();
        if (exp_count() == W) begin
            m_active    = exp_shadow();
            m_err       = 0;
            exp_strobes = 1;
        end else begin
            m_err       = 1;
            exp_strobes = 0;
        end
        n_shift = 0;
    endtask

    task automatic drive_shift(input bit b);
        @(negedge clk); sdi = b;
        repeat (2) @(negedge clk); sclk_in = 1'b1;
        repeat (5) @(negedge clk); sclk_in = 1'b0;
        repeat (5) @(negedge clk);
        model_shift(b);
    endtask

    task automatic drive_word(input logic [W-1:0] w, input int nbits);
        for (int i = 0; i < nbits; i++) drive_shift(w[i % W]);
    endtask

    task automatic drive_load();
        int base;
        base = strobe_hi;
        @(negedge clk); lclk_in = 1'b1;
        repeat (5) @(negedge clk); lclk_in = 1'b0;
        repeat (6) @(negedge clk);
        got_strobes = strobe_hi - base;
        model_load();
        $display("[TB] load: cfg_out=%h frame_err=%b bit_count=%0d strobes=%0d",
                 cfg_out, frame_err, bit_count, got_strobes);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_tests++; if (cfg_out !== RV) begin n_fail++; $display("FAIL reset_cfg: got %h want %h", cfg_out, RV); end
        n_tests++; if (bit_count !== '0 || frame_err !== 1'b0 || sdo !== 1'b0 || load_strobe !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: count=%0d err=%b sdo=%b strobe=%b want 0", bit_count, frame_err, sdo, load_strobe);
        end
        en_n = 1'b1; #1;
        n_tests++; if (cfg_out !== DV) begin n_fail++; $display("FAIL reset_disable: got %h want %h", cfg_out, DV); end
        en_n = 1'b0;
        // Both clocks already high when reset releases: no events expected.
        sclk_in = 1'b1; lclk_in = 1'b1;
        @(negedge clk); rst = 1'b0;
        repeat (10) @(negedge clk);
        sclk_in = 1'b0; lclk_in = 1'b0;
        repeat (10) @(negedge clk);
        n_tests++; if (bit_count !== '0 || frame_err !== 1'b0 || cfg_out !== RV) begin
            n_fail++; $display("FAIL release_edge: count=%0d err=%b cfg=%h want 0 0 %h", bit_count, frame_err, cfg_out, RV);
        end
    endtask

    task automatic test_latency();
        @(negedge clk); sdi = 1'b1;
        repeat (2) @(negedge clk); sclk_in = 1'b1;
        for (int k = 1; k <= S + 2; k++) begin
            @(posedge clk); #1;
            n_tests++;
            if (k < S + 2 && bit_count !== '0) begin
                n_fail++; $display("FAIL shift_latency_early: edge %0d count=%0d want 0", k, bit_count);
            end else if (k == S + 2 && bit_count !== CW'(1)) begin
                n_fail++; $display("FAIL shift_latency: edge %0d count=%0d want 1", k, bit_count);
            end
        end
        repeat (4) @(negedge clk); sclk_in = 1'b0;
        repeat (5) @(negedge clk);
        model_shift(1'b1);
    endtask

    task automatic test_short_frame();
        drive_word($urandom(), W - 1 - n_shift);
        n_tests++; if (bit_count !== CW'(exp_count())) begin n_fail++; $display("FAIL short_count: got %0d want %0d", bit_count, exp_count()); end
        drive_load();
        n_tests++; if (cfg_out !== m_active || frame_err !== 1'b1 || bit_count !== '0 || got_strobes != 0) begin
            n_fail++; $display("FAIL short_load: cfg=%h err=%b count=%0d strobes=%0d want %h 1 0 0", cfg_out, frame_err, bit_count, got_strobes, m_active);
        end
    endtask

    task automatic test_full_frame();
        logic [W-1:0] old_word;
        int           base;
        old_word = m_active;
        drive_word(24'hA5C3F0, W);
        n_tests++; if (bit_count !== CW'(W)) begin n_fail++; $display("FAIL full_count: got %0d want %0d", bit_count, W); end
        base = strobe_hi;
        @(negedge clk); lclk_in = 1'b1;
        for (int k = 1; k <= S + 4; k++) begin
            @(posedge clk); #1;
            n_tests++;
            if (k < S + 2 && cfg_out !== old_word) begin
                n_fail++; $display("FAIL load_latency_early: edge %0d cfg=%h want %h", k, cfg_out, old_word);
            end else if (k >= S + 2 && cfg_out !== 24'hA5C3F0) begin
                n_fail++; $display("FAIL load_latency: edge %0d cfg=%h want a5c3f0", k, cfg_out);
            end else if (load_strobe !== (k == S + 3)) begin
                n_fail++; $display("FAIL strobe_timing: edge %0d strobe=%b want %b", k, load_strobe, (k == S + 3));
            end
        end
        @(negedge clk); lclk_in = 1'b0;
        repeat (5) @(negedge clk);
        got_strobes = strobe_hi - base;
        model_load();
        $display("[TB] load: cfg_out=%h frame_err=%b bit_count=%0d strobes=%0d", cfg_out, frame_err, bit_count, got_strobes);
        n_tests++; if (cfg_out !== m_active || frame_err !== 1'b0 || bit_count !== '0 || got_strobes != 1) begin
            n_fail++; $display("FAIL full_load: cfg=%h err=%b count=%0d strobes=%0d want %h 0 0 1", cfg_out, frame_err, bit_count, got_strobes, m_active);
        end
    endtask

    task automatic test_overlong();
        for (int i = 0; i < 30; i++) drive_shift(1'($urandom()));
        n_tests++; if (bit_count !== CW'(W + 1)) begin n_fail++; $display("FAIL over_count: got %0d want %0d", bit_count, W + 1); end
        n_tests++; if (sdo !== exp_sdo()) begin n_fail++; $display("FAIL over_sdo: got %b want %b", sdo, exp_sdo()); end
        drive_load();
        n_tests++; if (cfg_out !== m_active || frame_err !== 1'b1 || bit_count !== '0 || got_strobes != 0) begin
            n_fail++; $display("FAIL over_load: cfg=%h err=%b count=%0d strobes=%0d want %h 1 0 0", cfg_out, frame_err, bit_count, got_strobes, m_active);
        end
    endtask

    task automatic test_aligned();
        bit b;
        int base;
        drive_word($urandom(), W);
        b = 1'($urandom());
        base = strobe_hi;
        @(negedge clk); sdi = b;
        repeat (2) @(negedge clk); sclk_in = 1'b1; lclk_in = 1'b1;
        repeat (5) @(negedge clk); sclk_in = 1'b0; lclk_in = 1'b0;
        repeat (6) @(negedge clk);
        got_strobes = strobe_hi - base;
        model_load();
        model_shift(b);
        $display("[TB] aligned load: cfg_out=%h bit_count=%0d strobes=%0d", cfg_out, bit_count, got_strobes);
        n_tests++; if (cfg_out !== m_active || got_strobes != 1 || frame_err !== 1'b0) begin
            n_fail++; $display("FAIL aligned_load: cfg=%h strobes=%0d err=%b want %h 1 0", cfg_out, got_strobes, frame_err, m_active);
        end
        n_tests++; if (bit_count !== CW'(1) || sdo !== exp_sdo()) begin
            n_fail++; $display("FAIL aligned_shift: count=%0d sdo=%b want 1 %b", bit_count, sdo, exp_sdo());
        end
    endtask

    task automatic test_reset_midframe();
        logic [W-1:0] w;
        drive_word($urandom(), 12 - n_shift);
        @(negedge clk); rst = 1'b1; #1;
        n_tests++; if (cfg_out !== RV || bit_count !== '0 || sdo !== 1'b0 || frame_err !== 1'b0) begin
            n_fail++; $display("FAIL midframe_reset: cfg=%h count=%0d sdo=%b err=%b want %h 0 0 0", cfg_out, bit_count, sdo, frame_err, RV);
        end
        hist.delete(); n_shift = 0; m_active = RV; m_err = 0;
        repeat (3) @(negedge clk); rst = 1'b0;
        repeat (6) @(negedge clk);
        w = W'($urandom());
        drive_word(w, 1);
        n_tests++; if (bit_count !== CW'(1)) begin n_fail++; $display("FAIL post_reset_first: count=%0d want 1", bit_count); end
        for (int i = 1; i < W; i++) drive_shift(w[i]);
        drive_load();
        n_tests++; if (cfg_out !== w || got_strobes != 1 || frame_err !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_load: cfg=%h strobes=%0d err=%b want %h 1 0", cfg_out, got_strobes, frame_err, w);
        end
    endtask

    task automatic test_enable();
        drive_word(24'h123456, W);
        drive_load();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); en_n = ~en_n; #1;
            n_tests++; if (cfg_out !== (en_n ? DV : 24'h123456)) begin
                n_fail++; $display("FAIL enable_cfg: en_n=%b got %h want %h", en_n, cfg_out, (en_n ? DV : 24'h123456));
            end
            n_tests++; if (sdo !== exp_sdo() || bit_count !== '0 || frame_err !== m_err || load_strobe !== 1'b0) begin
                n_fail++; $display("FAIL enable_side: sdo=%b count=%0d err=%b strobe=%b", sdo, bit_count, frame_err, load_strobe);
            end
        end
        en_n = 1'b0;
    endtask

    task automatic test_random();
        int lens[6] = '{W, W - 1, W + 1, W, 0, W + 3};
        for (int t = 0; t < 6; t++) begin
            drive_word(W'($urandom()), lens[t]);
            n_tests++; if (bit_count !== CW'(exp_count())) begin
                n_fail++; $display("FAIL rand_count[%0d]: got %0d want %0d", t, bit_count, exp_count());
            end
            drive_load();
            n_tests++; if (cfg_out !== m_active || frame_err !== m_err || got_strobes != exp_strobes || bit_count !== '0) begin
                n_fail++; $display("FAIL rand_load[%0d]: cfg=%h err=%b strobes=%0d count=%0d want %h %b %0d 0",
                                   t, cfg_out, frame_err, got_strobes, bit_count, m_active, m_err, exp_strobes);
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_latency();
        test_short_frame();
        test_full_frame();
        test_overlong();
        test_aligned();
        test_reset_midframe();
        test_enable();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
